display_scanner: RTL and testbench

Multiplexed N-digit seven-segment display driver for the display controller. It consumes the one-clock scan tick produced by the prescaler and rotates through the digits, one per tick. Each digit gets a hex-to-segment decode, an optional decimal point, optional leading-zero blanking, and an anti-ghosting guard interval between digits. New display values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new values.

---
 rtl/display_scanner.sv | 173 +++++++++++++++++
 tb/tb_display_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner: one digit per scan tick, dark guard
// between digits, and double-buffered values that switch only at frame start.
module display_scanner #(
  parameter int unsigned N_DIG     = 4,
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned GW        = 4
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Tick,
  input  logic               i_Load,
  input  logic [4*N_DIG-1:0] i_Value,
  input  logic [N_DIG-1:0]   i_DpMask,
  input  logic               i_LzBlank,
  output logic [6:0]         o_Seg,
  output logic               o_Dp,
  output logic [N_DIG-1:0]   o_An,
  output logic               o_FrameDone
);

  localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned VW = 4 * N_DIG;

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC);

  logic [1:0]       state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [GW-1:0]    gcnt, gcnt_nxt;
  logic [VW-1:0]    pending, pending_nxt;
  logic [N_DIG-1:0] pend_dp, pend_dp_nxt;
  logic             pend_flag, pend_flag_nxt;
  logic [VW-1:0]    shadow, shadow_nxt;
  logic [N_DIG-1:0] shadow_dp, shadow_dp_nxt;
  logic             frame_bnd;

  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [N_DIG-1:0] an_nxt;
  logic [3:0]       nib;
  logic             lz_run;
  logic             blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Scan sequencing and the pending/shadow double buffer
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    gcnt_nxt      = gcnt;
    pending_nxt   = pending;
    pend_dp_nxt   = pend_dp;
    pend_flag_nxt = pend_flag;
    shadow_nxt    = shadow;
    shadow_dp_nxt = shadow_dp;
    frame_bnd     = 1'b0;

    case (state)
      S_WAIT, S_SHOW: begin
        if (i_Tick) begin
          state_nxt = S_GUARD;
          gcnt_nxt  = GUARD_LOAD;
        end
      end
      S_GUARD: begin
        gcnt_nxt = gcnt - GW'(1);
        if (gcnt == GW'(1)) begin
          state_nxt = S_SHOW;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            frame_bnd = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: state_nxt = S_WAIT;
    endcase

    // A load coinciding with the frame boundary goes straight to the display
    if (frame_bnd) begin
      if (i_Load) begin
        shadow_nxt    = i_Value;
        shadow_dp_nxt = i_DpMask;
      end else if (pend_flag) begin
        shadow_nxt    = pending;
        shadow_dp_nxt = pend_dp;
      end
      pend_flag_nxt = 1'b0;
    end else if (i_Load) begin
      pending_nxt   = i_Value;
      pend_dp_nxt   = i_DpMask;
      pend_flag_nxt = 1'b1;
    end
  end

  // Next-cycle display image, derived from the next state so outputs switch with it
  always_comb begin
    nib    = 4'h0;
    lz_run = 1'b1;
    blank  = 1'b0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      lz_run = lz_run & (shadow_nxt[4*k +: 4] == 4'h0);
      if (idx_nxt == IW'(k)) begin
        nib   = shadow_nxt[4*k +: 4];
        blank = lz_run & (k != 0);
      end
    end

    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    an_nxt  = '1;
    if (state_nxt == S_SHOW) begin
      an_nxt  = ~(N_DIG'(1) << idx_nxt);
      seg_nxt = (i_LzBlank && blank) ? 7'h7F : seg_decode(nib);
      dp_nxt  = ~shadow_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state       <= S_WAIT;
      idx         <= IDX_LAST;
      gcnt        <= '0;
      pending     <= '0;
      pend_dp     <= '0;
      pend_flag   <= 1'b0;
      shadow      <= '0;
      shadow_dp   <= '0;
      o_Seg       <= 7'h7F;
      o_Dp        <= 1'b1;
      o_An        <= '1;
      o_FrameDone <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      gcnt        <= gcnt_nxt;
      pending     <= pending_nxt;
      pend_dp     <= pend_dp_nxt;
      pend_flag   <= pend_flag_nxt;
      shadow      <= shadow_nxt;
      shadow_dp   <= shadow_dp_nxt;
      o_Seg       <= seg_nxt;
      o_Dp        <= dp_nxt;
      o_An        <= an_nxt;
      o_FrameDone <= frame_bnd;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: timing-level reference model feeds a queue of
// expected digit images; a negedge monitor compares each digit as it lights.
module tb_display_scanner;
  localparam int N = 4;
  localparam int G = 2;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Tick = 1'b0;
  logic        i_Load = 1'b0;
  logic [15:0] i_Value = '0;
  logic [3:0]  i_DpMask = '0;
  logic        i_LzBlank = 1'b0;
  logic [6:0]  o_Seg;
  logic        o_Dp;
  logic [3:0]  o_An;
  logic        o_FrameDone;

  int checks = 0;
  int failures = 0;

  display_scanner #(.N_DIG(N), .GUARD_CYC(G), .GW(4)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Tick(i_Tick), .i_Load(i_Load),
    .i_Value(i_Value), .i_DpMask(i_DpMask), .i_LzBlank(i_LzBlank),
    .o_Seg(o_Seg), .o_Dp(o_Dp), .o_An(o_An), .o_FrameDone(o_FrameDone)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: digit shown G edges after an accepted tick
  bit          m_pend_show = 0;
  int          m_show_at = 0;
  int          m_cyc = 0;
  int          m_d = N - 1;
  logic [15:0] m_shadow = '0, m_pend = '0;
  logic [3:0]  m_sdp = '0, m_pdp = '0;
  bit          m_pflag = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pend_show = 0; m_d = N - 1; m_shadow = '0; m_sdp = '0;
    m_pend = '0; m_pdp = '0; m_pflag = 0;
  endtask

  task automatic step(input logic tk, input logic ld, input logic [15:0] v, input logic [3:0] dm);
    bit tick_ok;
    exp_t e;
    logic [15:0] sh;
    i_Tick = tk; i_Load = ld; i_Value = v; i_DpMask = dm;
    tick_ok = !m_pend_show;
    if (m_pend_show && m_cyc == m_show_at) begin
      m_pend_show = 0;
      m_d = (m_d + 1) % N;
      if (m_d == 0) begin
        if (ld) begin m_shadow = v; m_sdp = dm; end
        else if (m_pflag) begin m_shadow = m_pend; m_sdp = m_pdp; end
        m_pflag = 0;
      end else if (ld) begin
        m_pend = v; m_pdp = dm; m_pflag = 1;
      end
      sh = m_shadow >> (4 * m_d);
      e.an  = ~(4'b0001 << m_d);
      e.seg = (i_LzBlank && m_d != 0 && sh == 16'h0) ? 7'h7F : seg_tab[sh[3:0]];
      e.dp  = ~m_sdp[m_d];
      e.fd  = (m_d == 0);
      exp_q.push_back(e);
    end else if (ld) begin
      m_pend = v; m_pdp = dm; m_pflag = 1;
    end
    if (tk && tick_ok) begin
      m_pend_show = 1;
      m_show_at = m_cyc + G;
    end
    @(posedge i_Clk);
    m_cyc++;
    #1;
    i_Tick = 1'b0; i_Load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, i_Value, i_DpMask);
  endtask

  // Monitor: dark cycles must be fully dark, each lit digit matches the queue head
  logic [3:0] prev_an = 4'hF;
  bit         seen_show = 0;
  int         dark_len = 0;
  always @(negedge i_Clk) begin
    exp_t e;
    if (!i_Reset) begin
      seen_show = 0; dark_len = 0;
    end else if (o_An == 4'hF) begin
      check("dark_seg", 32'(o_Seg), 32'h7F);
      check("dark_dp", 32'(o_Dp), 32'h1);
      check("dark_framedone", 32'(o_FrameDone), 32'h0);
      dark_len++;
    end else begin
      if (prev_an == 4'hF) begin
        if (seen_show) check("guard_len", 32'(dark_len), 32'(G));
        if (exp_q.size() == 0) begin
          check("unexpected_digit_an", 32'(o_An), 32'hF);
        end else begin
          e = exp_q.pop_front();
          check("an", 32'(o_An), 32'(e.an));
          check("seg", 32'(o_Seg), 32'(e.seg));
          check("dp", 32'(o_Dp), 32'(e.dp));
          check("framedone", 32'(o_FrameDone), 32'(e.fd));
        end
        seen_show = 1;
      end else begin
        check("framedone_hold", 32'(o_FrameDone), 32'h0);
      end
      dark_len = 0;
    end
    prev_an = i_Reset ? o_An : 4'hF;
  end

  initial begin
    // Reset and idle with no ticks: display stays dark
    idle(4);
    i_Reset = 1'b1;
    idle(30);

    // Basic scan of 8A10 with DP on digit 2, plus a tick inside a guard
    step(1'b0, 1'b1, 16'h8A10, 4'b0100);
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 1'b0, i_Value, i_DpMask);
      if (n == 5) step(1'b1, 1'b0, i_Value, i_DpMask);
      else idle(1);
      idle(18);
    end

    // Leading-zero blanking
    i_LzBlank = 1'b1;
    step(1'b0, 1'b1, 16'h0070, 4'b0000);
    for (int n = 0; n < 8; n++) begin step(1'b1, 1'b0, i_Value, i_DpMask); idle(9); end
    step(1'b0, 1'b1, 16'h0000, 4'b0000);
    for (int n = 0; n < 8; n++) begin step(1'b1, 1'b0, i_Value, i_DpMask); idle(9); end
    i_LzBlank = 1'b0;

    // Two loads inside one frame: last one wins at the next frame
    for (int n = 0; n < 12; n++) begin
      step(1'b1, 1'b0, i_Value, i_DpMask);
      idle(G);
      if (m_d == 2) step(1'b0, 1'b1, 16'h1111, 4'b0000); else idle(1);
      if (m_d == 3) step(1'b0, 1'b1, 16'h2222, 4'b0000); else idle(1);
      idle(6);
    end

    // Loads coinciding with the frame-boundary edge
    for (int n = 0; n < 12; n++) begin
      step(1'b1, 1'b0, i_Value, i_DpMask);
      idle(G - 1);
      if (m_d == N - 1) step(1'b0, 1'b1, 16'($urandom), 4'($urandom));
      else idle(1);
      idle(5);
    end

    // Randomised ticks, loads and blanking
    for (int p = 0; p < 4; p++) begin
      i_LzBlank = 1'($urandom);
      for (int c = 0; c < 400; c++) begin
        step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 24) == 0),
             16'($urandom & (p[0] ? 32'h0000_00FF : 32'h0000_FFFF)), 4'($urandom));
      end
    end
    i_LzBlank = 1'b0;
    step(1'b0, 1'b1, 16'h5A3C, 4'b1001);

    // Reset while a digit is lit: dark at once, restart from digit 0 with zero shadow
    step(1'b1, 1'b0, i_Value, i_DpMask);
    idle(G + 3);
    check("pre_reset_lit", 32'(o_An != 4'hF), 32'h1);
    i_Reset = 1'b0;
    #1;
    check("reset_an", 32'(o_An), 32'hF);
    check("reset_seg", 32'(o_Seg), 32'h7F);
    check("reset_dp", 32'(o_Dp), 32'h1);
    check("reset_framedone", 32'(o_FrameDone), 32'h0);
    exp_q.delete();
    model_reset();
    idle(3);
    i_Reset = 1'b1;
    idle(2);
    step(1'b1, 1'b0, i_Value, i_DpMask);
    idle(G + 4);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
